// File: rtl/gpu_pixel_pipe_n_if.sv
// Beat-level bus between the interpolator, the pixel pipe and the VRAM write burst unit.
// The master side drives the input beat and i_ready; the slave side is the pixel pipe.
interface gpu_pixel_pipe_n_if #(
  parameter int unsigned NPIX = 2
);
  logic                 i_no_texture;
  logic                 i_no_blend;
  logic                 i_dither_on;
  logic [1:0]           i_trans_mode;
  logic                 i_check_mask;
  logic                 i_force_mask;
  logic                 i_valid;
  logic                 o_ready;
  logic [9:0]           i_scr_x;
  logic [8:0]           i_scr_y;
  logic [NPIX-1:0]      i_pix_en;
  logic [16*NPIX-1:0]   i_texel;
  logic [24*NPIX-1:0]   i_gouraud;
  logic [16*NPIX-1:0]   i_bg;
  logic                 o_valid;
  logic                 i_ready;
  logic [16*NPIX-1:0]   o_pixels;
  logic [NPIX-1:0]      o_wr_en;

  modport master (
    output i_no_texture, i_no_blend, i_dither_on, i_trans_mode, i_check_mask,
           i_force_mask, i_valid, i_scr_x, i_scr_y, i_pix_en, i_texel,
           i_gouraud, i_bg, i_ready,
    input  o_ready, o_valid, o_pixels, o_wr_en
  );

  modport slave (
    input  i_no_texture, i_no_blend, i_dither_on, i_trans_mode, i_check_mask,
           i_force_mask, i_valid, i_scr_x, i_scr_y, i_pix_en, i_texel,
           i_gouraud, i_bg, i_ready,
    output o_ready, o_valid, o_pixels, o_wr_en
  );
endinterface

// File: rtl/gpu_pixel_pipe_n.sv
// Three-stage pixel pipe: texture/Gouraud shading, semi-transparency blend,
// dither and 5:5:5:1 pack, with valid/ready back-pressure across all stages.
module gpu_pixel_pipe_n #(
  parameter int unsigned NPIX      = 2,
  parameter bit          DITHER_EN = 1'b1
) (
  input  logic              clk,
  input  logic              i_nrst,
  gpu_pixel_pipe_n_if.slave bus
);
  localparam int unsigned PW = 16 * NPIX;
  localparam int unsigned SW = 24 * NPIX;

  function automatic logic [7:0] shade(input logic [4:0] t, input logic [7:0] g);
    logic [15:0] p;
    p = {8'd0, t, 3'b000} * {8'd0, g};
    shade = p[15] ? 8'hFF : p[14:7];
  endfunction

  function automatic logic [7:0] blend(input logic [1:0] m, input logic [7:0] bv,
                                       input logic [7:0] f);
    logic signed [9:0] bb, ff, r;
    bb = $signed({2'b00, bv});
    ff = $signed({2'b00, f});
    case (m)
      2'd0:    r = (bb + ff) >>> 1;
      2'd1:    r = bb + ff;
      2'd2:    r = bb - ff;
      default: r = bb + (ff >>> 2);
    endcase
    if (r[9])              blend = '0;
    else if (r > 10'sd255) blend = '1;
    else                   blend = r[7:0];
  endfunction

  function automatic logic [4:0] dither5(input logic [7:0] b, input logic [1:0] y,
                                         input logic [1:0] x);
    logic signed [3:0] d;
    logic signed [9:0] v;
    case ({y, x})
      4'h0: d = -4'sd4;  4'h1: d = 4'sd0;   4'h2: d = -4'sd3;  4'h3: d = 4'sd1;
      4'h4: d = 4'sd2;   4'h5: d = -4'sd2;  4'h6: d = 4'sd3;   4'h7: d = -4'sd1;
      4'h8: d = -4'sd3;  4'h9: d = 4'sd1;   4'hA: d = -4'sd4;  4'hB: d = 4'sd0;
      4'hC: d = 4'sd3;   4'hD: d = -4'sd1;  4'hE: d = 4'sd2;   default: d = -4'sd2;
    endcase
    v = $signed({2'b00, b}) + $signed({{6{d[3]}}, d});
    if (v[9])              dither5 = '0;
    else if (v > 10'sd255) dither5 = '1;
    else                   dither5 = v[7:3];
  endfunction

  logic            adv;
  logic            v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic [SW-1:0]   s1_q, s1_d, b2_q, b2_d;
  logic [PW-1:0]   bg1_q, bg1_d, pix3_q, pix3_d;
  logic [NPIX-1:0] bl1_q, bl1_d, we1_q, we1_d, we2_q, we2_d, we3_q, we3_d;
  logic [NPIX-1:0] m1_q, m1_d, m2_q, m2_d;
  logic [1:0]      mode1_q, mode1_d;
  logic            dith1_q, dith1_d, dith2_q, dith2_d;
  logic [1:0]      x1_q, x1_d, y1_q, y1_d, x2_q, x2_d, y2_q, y2_d;
  logic [1:0]      xi;
  logic            unused_pos;

  // Only the low two coordinate bits matter: they index the 4x4 dither matrix.
  assign unused_pos = ^{bus.i_scr_x[9:2], bus.i_scr_y[8:2]};
  assign adv        = !v3_q | bus.i_ready;

  always_comb begin
    v1_d = v1_q;  s1_d = s1_q;  bg1_d = bg1_q;  bl1_d = bl1_q;  we1_d = we1_q;
    m1_d = m1_q;  mode1_d = mode1_q;  dith1_d = dith1_q;  x1_d = x1_q;  y1_d = y1_q;
    if (adv) begin
      v1_d    = bus.i_valid;
      bg1_d   = bus.i_bg;
      mode1_d = bus.i_trans_mode;
      dith1_d = DITHER_EN & bus.i_dither_on;
      x1_d    = bus.i_scr_x[1:0];
      y1_d    = bus.i_scr_y[1:0];
      for (int unsigned k = 0; k < NPIX; k++) begin
        for (int unsigned c = 0; c < 3; c++) begin
          s1_d[24*k+8*c +: 8] = bus.i_no_texture ? bus.i_gouraud[24*k+8*c +: 8]
                              : shade(bus.i_texel[16*k+5*c +: 5], bus.i_gouraud[24*k+8*c +: 8]);
        end
        bl1_d[k] = !bus.i_no_blend & (bus.i_no_texture | bus.i_texel[16*k+15]);
        m1_d[k]  = bus.i_force_mask | (!bus.i_no_texture & bus.i_texel[16*k+15]);
        we1_d[k] = bus.i_pix_en[k] & !(bus.i_check_mask & bus.i_bg[16*k+15])
                 & !(!bus.i_no_texture & (bus.i_texel[16*k +: 16] == 16'h0000));
      end
    end
  end

  always_comb begin
    v2_d = v2_q;  b2_d = b2_q;  dith2_d = dith2_q;  x2_d = x2_q;  y2_d = y2_q;
    we2_d = we2_q;  m2_d = m2_q;
    if (adv) begin
      v2_d    = v1_q;
      dith2_d = dith1_q;
      x2_d    = x1_q;
      y2_d    = y1_q;
      we2_d   = we1_q;
      m2_d    = m1_q;
      for (int unsigned k = 0; k < NPIX; k++) begin
        for (int unsigned c = 0; c < 3; c++) begin
          b2_d[24*k+8*c +: 8] = bl1_q[k]
              ? blend(mode1_q, {bg1_q[16*k+5*c +: 5], 3'b000}, s1_q[24*k+8*c +: 8])
              : s1_q[24*k+8*c +: 8];
        end
      end
    end
  end

  always_comb begin
    v3_d = v3_q;  pix3_d = pix3_q;  we3_d = we3_q;  xi = '0;
    if (adv) begin
      v3_d  = v2_q;
      we3_d = we2_q;
      for (int unsigned k = 0; k < NPIX; k++) begin
        // Pixel k sits at scr_x + k; the 2-bit add wraps exactly like x mod 4.
        xi = x2_q + 2'(k);
        for (int unsigned c = 0; c < 3; c++) begin
          pix3_d[16*k+5*c +: 5] = dith2_q ? dither5(b2_q[24*k+8*c +: 8], y2_q, xi)
                                          : b2_q[24*k+8*c+3 +: 5];
        end
        pix3_d[16*k+15] = m2_q[k];
      end
    end
  end

  always_ff @(posedge clk or negedge i_nrst) begin
    if (!i_nrst) begin
      v1_q <= '0;  s1_q <= '0;  bg1_q <= '0;  bl1_q <= '0;  we1_q <= '0;  m1_q <= '0;
      mode1_q <= '0;  dith1_q <= '0;  x1_q <= '0;  y1_q <= '0;
      v2_q <= '0;  b2_q <= '0;  dith2_q <= '0;  x2_q <= '0;  y2_q <= '0;
      we2_q <= '0;  m2_q <= '0;
      v3_q <= '0;  pix3_q <= '0;  we3_q <= '0;
    end else begin
      v1_q <= v1_d;  s1_q <= s1_d;  bg1_q <= bg1_d;  bl1_q <= bl1_d;  we1_q <= we1_d;
      m1_q <= m1_d;  mode1_q <= mode1_d;  dith1_q <= dith1_d;  x1_q <= x1_d;  y1_q <= y1_d;
      v2_q <= v2_d;  b2_q <= b2_d;  dith2_q <= dith2_d;  x2_q <= x2_d;  y2_q <= y2_d;
      we2_q <= we2_d;  m2_q <= m2_d;
      v3_q <= v3_d;  pix3_q <= pix3_d;  we3_q <= we3_d;
    end
  end

  assign bus.o_ready  = adv;
  assign bus.o_valid  = v3_q;
  assign bus.o_pixels = pix3_q;
  assign bus.o_wr_en  = we3_q;
endmodule

// File: tb/tb_gpu_pixel_pipe_n.sv
// Bench for gpu_pixel_pipe_n (NPIX=2): scenario tasks plus a scoreboard of
// model-predicted beats popped as the pipe presents them.
module tb_gpu_pixel_pipe_n;
  localparam int unsigned NPIX = 2;

  typedef struct packed {
    logic        no_tex;
    logic        no_blend;
    logic        dith;
    logic [1:0]  mode;
    logic        chk;
    logic        fm;
    logic [9:0]  x;
    logic [8:0]  y;
    logic [1:0]  en;
    logic [31:0] tex;
    logic [47:0] gour;
    logic [31:0] bg;
  } beat_t;

  logic        clk = 1'b0;
  logic        i_nrst;
  int          total = 0;
  int          bad = 0;
  int          rx_cnt = 0;
  int          dt_tab [16] = '{-4, 0, -3, 1, 2, -2, 3, -1, -3, 1, -4, 0, 3, -1, 2, -2};
  logic [31:0] exp_pix_q [$];
  logic [1:0]  exp_we_q [$];
  logic [31:0] last_pix, prev_pix, ep;
  logic [1:0]  last_we, prev_we, ew;
  logic        prev_stall = 1'b0;
  logic        bp_on = 1'b0;
  logic [3:0]  bp_pat = 4'b1001;
  logic [1:0]  bp_idx = 2'd0;

  gpu_pixel_pipe_n_if #(.NPIX(NPIX)) bus ();
  gpu_pixel_pipe_n #(.NPIX(NPIX), .DITHER_EN(1'b1)) dut (.clk(clk), .i_nrst(i_nrst), .bus(bus));

  always #5 clk = ~clk;

  // i_ready source: constant 1, or the 1,0,0,1 back-pressure pattern.
  always @(posedge clk) begin
    #1;
    bus.i_ready = bp_on ? bp_pat[bp_idx] : 1'b1;
    if (bp_on) bp_idx = bp_idx + 2'd1;
  end

  always @(negedge clk) begin
    if (i_nrst === 1'b1) begin
      if (prev_stall) begin
        total++;
        if (bus.o_pixels !== prev_pix || bus.o_wr_en !== prev_we || bus.o_valid !== 1'b1) begin
          bad++;
          $display("FAIL stall_hold: pix=%h we=%b v=%b want pix=%h we=%b v=1",
                   bus.o_pixels, bus.o_wr_en, bus.o_valid, prev_pix, prev_we);
        end
      end
      prev_stall = bus.o_valid & !bus.i_ready;
      prev_pix   = bus.o_pixels;
      prev_we    = bus.o_wr_en;
      if (bus.o_valid === 1'b1 && bus.i_ready === 1'b1) begin
        rx_cnt++;
        last_pix = bus.o_pixels;
        last_we  = bus.o_wr_en;
        total++;
        if (exp_pix_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_beat: pix=%h we=%b want no beat", bus.o_pixels, bus.o_wr_en);
        end else begin
          ep = exp_pix_q.pop_front();
          ew = exp_we_q.pop_front();
          if (bus.o_pixels !== ep || bus.o_wr_en !== ew) begin
            bad++;
            $display("FAIL sb_beat: pix=%h we=%b want pix=%h we=%b", bus.o_pixels, bus.o_wr_en, ep, ew);
          end
        end
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  function automatic beat_t blank();
    beat_t b;
    b = '0;
    b.en = 2'b11;
    return b;
  endfunction

  function automatic logic [16:0] model_px(input beat_t b, input int unsigned k);
    logic [15:0] tex, bg, px;
    logic [23:0] gv;
    int s, bv, r, xi, yi;
    logic bl;
    tex = b.tex[16*k +: 16];
    bg  = b.bg[16*k +: 16];
    gv  = b.gour[24*k +: 24];
    bl  = !b.no_blend && (b.no_tex || tex[15]);
    xi  = (int'(b.x) + int'(k)) % 4;
    yi  = int'(b.y) % 4;
    px  = '0;
    for (int unsigned c = 0; c < 3; c++) begin
      if (b.no_tex) s = int'(gv[8*c +: 8]);
      else begin
        s = (int'(tex[5*c +: 5]) * 8 * int'(gv[8*c +: 8])) / 128;
        if (s > 255) s = 255;
      end
      if (bl) begin
        bv = int'(bg[5*c +: 5]) * 8;
        case (b.mode)
          2'd0:    r = (bv + s) / 2;
          2'd1:    r = bv + s;
          2'd2:    r = bv - s;
          default: r = bv + s / 4;
        endcase
        if (r < 0) r = 0;
        if (r > 255) r = 255;
      end else r = s;
      if (b.dith) begin
        r = r + dt_tab[yi*4 + xi];
        if (r < 0) r = 0;
        if (r > 255) r = 255;
      end
      px[5*c +: 5] = 5'(r / 8);
    end
    px[15] = b.fm | (!b.no_tex & tex[15]);
    return {b.en[k] & !(b.chk & bg[15]) & !(!b.no_tex && tex == 16'h0000), px};
  endfunction

  task automatic idle();
    bus.i_valid = 1'b0;  bus.i_no_texture = 1'b0;  bus.i_no_blend = 1'b0;
    bus.i_dither_on = 1'b0;  bus.i_trans_mode = 2'd0;  bus.i_check_mask = 1'b0;
    bus.i_force_mask = 1'b0;  bus.i_scr_x = '0;  bus.i_scr_y = '0;  bus.i_pix_en = '0;
    bus.i_texel = '0;  bus.i_gouraud = '0;  bus.i_bg = '0;
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input beat_t b);
    logic [31:0] xp;
    logic [1:0]  xw;
    logic [16:0] m;
    bus.i_no_texture = b.no_tex;  bus.i_no_blend = b.no_blend;  bus.i_dither_on = b.dith;
    bus.i_trans_mode = b.mode;  bus.i_check_mask = b.chk;  bus.i_force_mask = b.fm;
    bus.i_scr_x = b.x;  bus.i_scr_y = b.y;  bus.i_pix_en = b.en;
    bus.i_texel = b.tex;  bus.i_gouraud = b.gour;  bus.i_bg = b.bg;
    bus.i_valid = 1'b1;
    for (int unsigned k = 0; k < NPIX; k++) begin
      m = model_px(b, k);
      xp[16*k +: 16] = m[15:0];
      xw[k] = m[16];
    end
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (bus.o_ready === 1'b1) begin
        exp_pix_q.push_back(xp);
        exp_we_q.push_back(xw);
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    total++; bad++;
    $display("FAIL send_timeout: o_ready=%b want 1", bus.o_ready);
    bus.i_valid = 1'b0;
  endtask

  task automatic wait_rx(input int target);
    for (int n = 0; n < 200 && rx_cnt < target; n++) @(posedge clk);
    #1;
    if (rx_cnt < target) begin
      total++; bad++;
      $display("FAIL rx_timeout: got=%0d want=%0d", rx_cnt, target);
    end
  endtask

  task automatic test_reset();
    i_nrst = 1'b0;
    idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (bus.o_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got=%b want=0", bus.o_valid); end
    total++; if (bus.o_wr_en !== 2'b00) begin bad++; $display("FAIL rst_wr_en: got=%b want=00", bus.o_wr_en); end
    total++; if (bus.o_pixels !== 32'h0) begin bad++; $display("FAIL rst_pixels: got=%h want=0", bus.o_pixels); end
    total++; if (bus.o_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got=%b want=1", bus.o_ready); end
    @(posedge clk); #1;
    i_nrst = 1'b1;
  endtask

  task automatic test_flat();
    beat_t b;
    int lat;
    b = blank();
    b.no_tex = 1'b1;  b.no_blend = 1'b1;
    b.gour = {24'h0080FF, 24'h0080FF};
    send(b);
    lat = 0;
    for (int n = 1; n <= 10 && lat == 0; n++) begin
      @(negedge clk);
      if (bus.o_valid === 1'b1) lat = n;
    end
    total++; if (lat != 3) begin bad++; $display("FAIL flat_latency: got=%0d want=3", lat); end
    total++; if (bus.o_pixels[15:0] !== 16'h021F) begin bad++; $display("FAIL flat_pix0: got=%h want=021f", bus.o_pixels[15:0]); end
    total++; if (bus.o_wr_en !== 2'b11) begin bad++; $display("FAIL flat_wr_en: got=%b want=11", bus.o_wr_en); end
    @(posedge clk); #1;
  endtask

  task automatic test_texture();
    beat_t b;
    int base;
    b = blank();
    b.tex = {16'h001F, 16'h001F};  b.no_blend = 1'b1;
    b.gour = {24'h0000FF, 24'h808080};
    base = rx_cnt;  send(b);  wait_rx(base + 1);
    total++; if (last_pix !== {16'h001F, 16'h001F}) begin bad++; $display("FAIL tex_gain_clamp: got=%h want=001f001f", last_pix); end
    b.tex = {16'h0000, 16'h7C00};
    b.gour = {24'h808080, 24'h800000};
    base = rx_cnt;  send(b);  wait_rx(base + 1);
    total++; if (last_pix !== {16'h0000, 16'h7C00}) begin bad++; $display("FAIL tex_blue: got=%h want=00007c00", last_pix); end
    total++; if (last_we !== 2'b01) begin bad++; $display("FAIL tex_zero_discard: got=%b want=01", last_we); end
  endtask

  task automatic test_blend();
    beat_t b;
    int base;
    b = blank();
    b.mode = 2'd2;  b.tex = {16'h8008, 16'h8008};
    b.gour = {24'h000080, 24'h000080};  b.bg = {16'h0004, 16'h0004};
    base = rx_cnt;  send(b);  wait_rx(base + 1);
    total++; if (last_pix !== {16'h8000, 16'h8000}) begin bad++; $display("FAIL blend_sub: got=%h want=80008000", last_pix); end
    b = blank();
    b.no_tex = 1'b1;  b.mode = 2'd3;
    b.gour = {24'h000028, 24'h000028};  b.bg = {16'h001F, 16'h001F};
    base = rx_cnt;  send(b);  wait_rx(base + 1);
    total++; if (last_pix !== {16'h001F, 16'h001F}) begin bad++; $display("FAIL blend_quarter: got=%h want=001f001f", last_pix); end
    b.mode = 2'd0;
    b.gour = {24'h0000C8, 24'h0000C8};  b.bg = {16'h001F, 16'h0000};
    base = rx_cnt;  send(b);  wait_rx(base + 1);
    total++; if (last_pix !== {16'h001C, 16'h000C}) begin bad++; $display("FAIL blend_avg: got=%h want=001c000c", last_pix); end
  endtask

  task automatic test_dither();
    beat_t b;
    int base;
    b = blank();
    b.no_tex = 1'b1;  b.no_blend = 1'b1;  b.dith = 1'b1;
    b.x = 10'd0;  b.y = 9'd4;  b.gour = {24'h00000F, 24'h000003};
    base = rx_cnt;  send(b);  wait_rx(base + 1);
    total++; if (last_pix !== {16'h0001, 16'h0000}) begin bad++; $display("FAIL dither_floor: got=%h want=00010000", last_pix); end
    b.x = 10'd2;  b.y = 9'd1;  b.gour = {24'h00000E, 24'h00000E};
    base = rx_cnt;  send(b);  wait_rx(base + 1);
    total++; if (last_pix !== {16'h0001, 16'h0002}) begin bad++; $display("FAIL dither_row1: got=%h want=00010002", last_pix); end
    b.x = 10'd1023;  b.y = 9'd0;  b.gour = {24'h000008, 24'h000008};
    base = rx_cnt;  send(b);  wait_rx(base + 1);
    total++; if (last_pix !== {16'h0000, 16'h0001}) begin bad++; $display("FAIL dither_xwrap: got=%h want=00000001", last_pix); end
  endtask

  task automatic test_mask();
    beat_t b;
    int base;
    b = blank();
    b.no_tex = 1'b1;  b.no_blend = 1'b1;  b.chk = 1'b1;  b.fm = 1'b1;
    b.bg = {16'h8000, 16'h0000};
    base = rx_cnt;  send(b);  wait_rx(base + 1);
    total++; if (last_we !== 2'b01) begin bad++; $display("FAIL mask_check: got=%b want=01", last_we); end
    total++; if (last_pix !== {16'h8000, 16'h8000}) begin bad++; $display("FAIL mask_force: got=%h want=80008000", last_pix); end
    b.chk = 1'b0;  b.fm = 1'b0;  b.en = 2'b10;
    b.gour = {24'h0000FF, 24'h0000FF};
    base = rx_cnt;  send(b);  wait_rx(base + 1);
    total++; if (last_we !== 2'b10) begin bad++; $display("FAIL pix_en: got=%b want=10", last_we); end
    total++; if (last_pix !== {16'h001F, 16'h001F}) begin bad++; $display("FAIL pix_en_data: got=%h want=001f001f", last_pix); end
  endtask

  task automatic test_back_to_back();
    beat_t b;
    int base;
    bp_on = 1'b1;
    base = rx_cnt;
    for (int unsigned i = 0; i < 6; i++) begin
      b.no_tex = 1'($urandom);  b.no_blend = 1'($urandom);  b.dith = 1'($urandom);
      b.mode = 2'($urandom);  b.chk = 1'($urandom);  b.fm = 1'($urandom);
      b.x = 10'($urandom_range(0, 1023));  b.y = 9'($urandom_range(0, 511));
      b.en = 2'($urandom);  b.tex = $urandom;  b.bg = $urandom;
      b.gour = {16'($urandom), $urandom};
      send(b);
    end
    wait_rx(base + 6);
    repeat (8) @(posedge clk);
    #1;
    total++; if (rx_cnt - base != 6) begin bad++; $display("FAIL b2b_count: got=%0d want=6", rx_cnt - base); end
    total++; if (exp_pix_q.size() != 0) begin bad++; $display("FAIL b2b_pending: got=%0d want=0", exp_pix_q.size()); end
    bp_on = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    beat_t b;
    int lat, base;
    time t0;
    b = blank();
    b.no_tex = 1'b1;  b.no_blend = 1'b1;
    b.gour = {24'h0080FF, 24'h0080FF};
    repeat (3) send(b);
    total++; if (bus.o_valid !== 1'b1) begin bad++; $display("FAIL mid_prefill: got=%b want=1", bus.o_valid); end
    i_nrst = 1'b0;
    #1;
    total++; if (bus.o_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid: got=%b want=0", bus.o_valid); end
    total++; if (bus.o_wr_en !== 2'b00) begin bad++; $display("FAIL mid_rst_wr_en: got=%b want=00", bus.o_wr_en); end
    exp_pix_q.delete();
    exp_we_q.delete();
    @(posedge clk); #1;
    i_nrst = 1'b1;
    base = rx_cnt;
    t0 = $time;
    send(b);
    total++; if ($time - t0 != 10) begin bad++; $display("FAIL post_rst_accept: got=%0t want=10", $time - t0); end
    lat = 0;
    for (int n = 1; n <= 10 && lat == 0; n++) begin
      @(negedge clk);
      if (bus.o_valid === 1'b1) lat = n;
    end
    total++; if (lat != 3) begin bad++; $display("FAIL post_rst_latency: got=%0d want=3", lat); end
    wait_rx(base + 1);
    total++; if (last_pix !== {16'h021F, 16'h021F}) begin bad++; $display("FAIL post_rst_pix: got=%h want=021f021f", last_pix); end
  endtask

  initial begin
    test_reset();
    test_flat();
    test_texture();
    test_blend();
    test_dither();
    test_mask();
    test_back_to_back();
    test_reset_mid();
    repeat (6) @(posedge clk);
    #1;
    total++; if (exp_pix_q.size() != 0) begin bad++; $display("FAIL final_drain: got=%0d want=0", exp_pix_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
